// File: rtl/coin_collector_n.sv
// coin_collector_n: scores ball/coin overlaps once per frame tick.
// A frame tick is a rising edge of frame_clk, sampled on Clk. In play
// state each coin inside the hit radius that is not already collected
// adds to a saturating score. A coin at or left of RECYCLE_X becomes
// visible again (its collected flag is cleared).
// Optional feature macro: COIN_COMBO_EN. When it is defined, hits inside
// a COMBO_WINDOW-frame window after a scoring tick are worth double.
module coin_collector_n #(
  parameter int unsigned NUM_COINS    = 4,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned SCORE_W      = 7,
  parameter int unsigned HIT_R2       = 100,
  parameter int unsigned RECYCLE_X    = 144,
  parameter int unsigned COMBO_WINDOW = 60
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic [COORD_W-1:0]           Ball_X_Pos,
  input  logic [COORD_W-1:0]           Ball_Y_Pos,
  input  logic [NUM_COINS*COORD_W-1:0] coin_X_Pos,
  input  logic [NUM_COINS*COORD_W-1:0] coin_Y_Pos,
  input  logic [1:0]                   game_state,
  output logic [SCORE_W-1:0]           score,
  output logic [NUM_COINS-1:0]         coin_collected,
  output logic                         collect_pulse,
  output logic                         score_sat,
  output logic                         combo_active
);

  typedef enum logic [1:0] {
    GS_START = 2'd0,
    GS_PLAY  = 2'd1,
    GS_OVER  = 2'd2,
    GS_HOLD  = 2'd3
  } game_state_e;

  localparam int unsigned D_W   = 2*COORD_W + 3;
  localparam int unsigned CNT_W = $clog2(NUM_COINS + 1);
  localparam int unsigned ADD_W = CNT_W + 1;
  localparam int unsigned SUM_W = SCORE_W + ADD_W;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_e            gs;
  logic [1:0]             fsync;
  logic                   sync_live;
  logic                   sync_armed;
  logic                   tick;
  logic                   play_tick;
  logic [NUM_COINS-1:0]   new_hit;
  logic [NUM_COINS-1:0]   recycle;
  logic [CNT_W-1:0]       hit_cnt;
  logic [ADD_W-1:0]       add_val;
  logic [SUM_W-1:0]       sum;
  logic [SCORE_W-1:0]     score_nxt;
  logic                   double_val;

  assign gs = game_state_e'(game_state);

  // Squared distance with both deltas sign-extended so the sum cannot overflow.
  function automatic logic in_radius(input logic [COORD_W-1:0] cx,
                                     input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] bx,
                                     input logic [COORD_W-1:0] by);
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic signed [D_W-1:0]   dxe;
    logic signed [D_W-1:0]   dye;
    logic [D_W-1:0]          d2;
    dx  = $signed({1'b0, cx}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, cy}) - $signed({1'b0, by});
    dxe = D_W'(dx);
    dye = D_W'(dy);
    d2  = $unsigned(dxe*dxe + dye*dye);
    return d2 <= D_W'(HIT_R2);
  endfunction

  // sync_armed requires a genuinely sampled low level before the first
  // tick after reset, so a frame_clk held high through reset cannot fire.
  assign tick      = fsync[0] & ~fsync[1] & sync_armed;
  assign play_tick = tick && (gs == GS_PLAY);

  // Per-coin hit/recycle classification and the score to apply on a tick.
  always_comb begin
    new_hit = '0;
    recycle = '0;
    hit_cnt = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      if (coin_X_Pos[i*COORD_W +: COORD_W] <= COORD_W'(RECYCLE_X)) begin
        recycle[i] = 1'b1;
      end else if (!coin_collected[i] &&
                   in_radius(coin_X_Pos[i*COORD_W +: COORD_W],
                             coin_Y_Pos[i*COORD_W +: COORD_W],
                             Ball_X_Pos, Ball_Y_Pos)) begin
        new_hit[i] = 1'b1;
      end
      hit_cnt = hit_cnt + CNT_W'(new_hit[i]);
    end
    add_val   = double_val ? {hit_cnt, 1'b0} : {1'b0, hit_cnt};
    sum       = SUM_W'(score) + SUM_W'(add_val);
    score_nxt = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_nxt_trunc(sum);
  end

  function automatic logic [SCORE_W-1:0] score_nxt_trunc(input logic [SUM_W-1:0] s);
    return s[SCORE_W-1:0];
  endfunction

  // Frame-edge synchroniser, score and coin flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsync          <= '0;
      sync_live      <= 1'b0;
      sync_armed     <= 1'b0;
      score          <= '0;
      coin_collected <= '0;
      collect_pulse  <= 1'b0;
      score_sat      <= 1'b0;
    end else begin
      fsync         <= {fsync[0], frame_clk};
      sync_live     <= 1'b1;
      collect_pulse <= 1'b0;
      if (sync_live && !fsync[0]) begin
        sync_armed <= 1'b1;
      end
      if (gs == GS_START) begin
        score          <= '0;
        coin_collected <= '0;
        score_sat      <= 1'b0;
      end else if (play_tick) begin
        coin_collected <= (coin_collected | new_hit) & ~recycle;
        score          <= score_nxt;
        score_sat      <= (score_nxt == SCORE_MAX);
        collect_pulse  <= (hit_cnt != '0);
      end
    end
  end

`ifdef COIN_COMBO_EN
  localparam int unsigned CW = (COMBO_WINDOW < 1) ? 1 : $clog2(COMBO_WINDOW + 1);
  logic [CW-1:0] combo_cnt;

  assign double_val = combo_active;

  // Combo window counter: reload on scoring ticks, count down on other play ticks.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      combo_cnt    <= '0;
      combo_active <= 1'b0;
    end else if (gs == GS_START) begin
      combo_cnt    <= '0;
      combo_active <= 1'b0;
    end else if (play_tick) begin
      if (hit_cnt != '0) begin
        combo_cnt    <= CW'(COMBO_WINDOW);
        combo_active <= (COMBO_WINDOW != 0);
      end else if (combo_cnt != '0) begin
        combo_cnt    <= combo_cnt - CW'(1);
        combo_active <= (combo_cnt != CW'(1));
      end
    end
  end
`else
  assign double_val   = 1'b0;
  assign combo_active = 1'b0;
`endif

endmodule

// File: tb/tb_coin_collector_n.sv
// Randomised and directed bench for coin_collector_n with a frame-level
// reference model (integer distances, saturating integer score).
module tb_coin_collector_n;

  localparam int unsigned NUM_COINS    = 4;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned SCORE_W      = 7;
  localparam int unsigned HIT_R2       = 100;
  localparam int unsigned RECYCLE_X    = 144;
  localparam int unsigned COMBO_WINDOW = 60;
  localparam int unsigned SMAX         = (1 << SCORE_W) - 1;
`ifdef COIN_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic                         Clk = 1'b0;
  logic                         Reset_n;
  logic                         frame_clk;
  logic [COORD_W-1:0]           Ball_X_Pos;
  logic [COORD_W-1:0]           Ball_Y_Pos;
  logic [NUM_COINS*COORD_W-1:0] coin_X_Pos;
  logic [NUM_COINS*COORD_W-1:0] coin_Y_Pos;
  logic [1:0]                   game_state;
  logic [SCORE_W-1:0]           score;
  logic [NUM_COINS-1:0]         coin_collected;
  logic                         collect_pulse;
  logic                         score_sat;
  logic                         combo_active;

  logic [COORD_W-1:0] cx [NUM_COINS];
  logic [COORD_W-1:0] cy [NUM_COINS];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  int unsigned          m_score;
  logic [NUM_COINS-1:0] m_col;
  int unsigned          m_cnt;
  int unsigned          m_pulse;

  coin_collector_n #(
    .NUM_COINS(NUM_COINS), .COORD_W(COORD_W), .SCORE_W(SCORE_W),
    .HIT_R2(HIT_R2), .RECYCLE_X(RECYCLE_X), .COMBO_WINDOW(COMBO_WINDOW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .Ball_X_Pos(Ball_X_Pos), .Ball_Y_Pos(Ball_Y_Pos),
    .coin_X_Pos(coin_X_Pos), .coin_Y_Pos(coin_Y_Pos),
    .game_state(game_state), .score(score), .coin_collected(coin_collected),
    .collect_pulse(collect_pulse), .score_sat(score_sat),
    .combo_active(combo_active)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    coin_X_Pos = '0;
    coin_Y_Pos = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      coin_X_Pos[i*COORD_W +: COORD_W] = cx[i];
      coin_Y_Pos[i*COORD_W +: COORD_W] = cy[i];
    end
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_score = 0;
    m_col   = '0;
    m_cnt   = 0;
  endtask

  // One frame evaluated from the rules: integer distance, recycle first.
  task automatic model_tick();
    int hits;
    int dx, dy;
    int unsigned val;
    hits    = 0;
    m_pulse = 0;
    if (game_state != 2'd1) return;
    for (int i = 0; i < NUM_COINS; i++) begin
      dx = int'(cx[i]) - int'(Ball_X_Pos);
      dy = int'(cy[i]) - int'(Ball_Y_Pos);
      if (cx[i] <= RECYCLE_X) m_col[i] = 1'b0;
      else if (!m_col[i] && (dx*dx + dy*dy <= int'(HIT_R2))) begin
        hits++;
        m_col[i] = 1'b1;
      end
    end
    val     = (COMBO && m_cnt != 0) ? 2 : 1;
    m_score = m_score + hits * val;
    if (m_score > SMAX) m_score = SMAX;
    if (COMBO) begin
      if (hits > 0) m_cnt = COMBO_WINDOW;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
    m_pulse = (hits > 0) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_score"}, score, m_score);
    check_eq({tag, "_col"}, coin_collected, m_col);
    check_eq({tag, "_sat"}, score_sat, (m_score == SMAX) ? 1 : 0);
    check_eq({tag, "_combo"}, combo_active, (m_cnt != 0) ? 1 : 0);
  endtask

  // Called at a falling Clk edge; raises frame_clk, counts pulse cycles.
  task automatic do_tick(input string tag);
    int unsigned pulses;
    pulses    = 0;
    frame_clk = 1'b1;
    model_tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (collect_pulse) pulses++;
    end
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    check_eq({tag, "_pulse"}, pulses, m_pulse);
    check_outputs(tag);
  endtask

  task automatic set_state(input logic [1:0] v);
    game_state = v;
    if (v == 2'd0) model_clear();
    repeat (2) @(negedge Clk);
  endtask

  task automatic place(input int i, input int unsigned x, input int unsigned y);
    cx[i] = COORD_W'(x);
    cy[i] = COORD_W'(y);
  endtask

  task automatic all_far();
    for (int i = 0; i < NUM_COINS; i++) place(i, 600, 1000);
  endtask

  task automatic all_recycle();
    for (int i = 0; i < NUM_COINS; i++) place(i, 100, 1000);
  endtask

  initial begin
    int unsigned nh;
    int unsigned bx, by, sel;
    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    game_state = 2'd0;
    Ball_X_Pos = 10'd200;
    Ball_Y_Pos = 10'd100;
    all_far();
    model_clear();
    m_pulse = 0;
    repeat (3) @(negedge Clk);
    check_eq("rst_pulse", collect_pulse, 0);
    check_outputs("rst");
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Single hit at exactly the radius, then no double count.
    set_state(2'd1);
    place(0, 206, 108);
    do_tick("single");
    check_eq("single_const", score, 1);
    do_tick("single_again");

    // Three simultaneous hits.
    set_state(2'd0);
    set_state(2'd1);
    place(0, 203, 100); place(1, 200, 105); place(2, 195, 97); place(3, 600, 1000);
    do_tick("triple");
    check_eq("triple_col", coin_collected, 4'b0111);

    // Recycle boundary.
    set_state(2'd0);
    set_state(2'd1);
    all_far();
    Ball_X_Pos = 10'd150;
    place(1, 144, 100);
    do_tick("rx144");
    place(1, 145, 100);
    do_tick("rx145");

    // Saturation.
    set_state(2'd0);
    set_state(2'd1);
    Ball_X_Pos = 10'd300; Ball_Y_Pos = 10'd300;
    while (m_score < 126) begin
      nh = 126 - m_score;
      if (nh > NUM_COINS) nh = NUM_COINS;
      all_far();
      for (int i = 0; i < int'(nh); i++) place(i, 300 + i, 300);
      do_tick("preload");
      all_recycle();
      do_tick("preload_rc");
    end
    all_far();
    place(0, 301, 300); place(1, 300, 302);
    do_tick("sat");
    check_eq("sat_const", score, SMAX);
    all_recycle();
    do_tick("sat_rc");
    all_far();
    place(2, 300, 300);
    do_tick("sat_more");

    // Hold states, start-state clear, asynchronous reset mid-frame.
    all_recycle();
    do_tick("hold_rc");
    all_far();
    place(0, 300, 300);
    set_state(2'd2);
    do_tick("over");
    set_state(2'd3);
    do_tick("hold");
    game_state = 2'd0;
    @(posedge Clk); #1;
    check_eq("start_score", score, 0);
    check_eq("start_col", coin_collected, 0);
    check_eq("start_sat", score_sat, 0);
    model_clear();
    @(negedge Clk);
    set_state(2'd1);
    do_tick("pre_rst");
    all_recycle();
    do_tick("pre_rst_rc");
    all_far();
    place(0, 300, 300);
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("arst_pulse", collect_pulse, 0);
    check_outputs("arst");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check_eq("no_phantom_pulse", collect_pulse, 0);
    check_outputs("no_phantom");
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    do_tick("post_rst");

`ifdef COIN_COMBO_EN
    set_state(2'd0);
    set_state(2'd1);
    all_far();
    place(0, 300, 300);
    do_tick("combo_first");
    all_far();
    repeat (9) do_tick("combo_gap");
    place(1, 300, 300);
    do_tick("combo_second");
    check_eq("combo_second_const", score, 3);
    all_far();
    repeat (60) do_tick("combo_decay");
    place(2, 300, 300);
    do_tick("combo_late");
`endif

    // Randomised frames.
    set_state(2'd0);
    set_state(2'd1);
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) set_state(2'd0);
      else if (sel == 1) set_state(2'd2);
      else if (sel == 2) set_state(2'd3);
      else if (sel < 8) set_state(2'd1);
      bx = $urandom_range(150, 800);
      by = $urandom_range(150, 800);
      Ball_X_Pos = COORD_W'(bx);
      Ball_Y_Pos = COORD_W'(by);
      for (int i = 0; i < NUM_COINS; i++) begin
        sel = $urandom_range(0, 3);
        if (sel < 2) place(i, bx + $urandom_range(0, 24) - 12, by + $urandom_range(0, 24) - 12);
        else if (sel == 2) place(i, $urandom_range(140, 150), by);
        else place(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      do_tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_collector_n.md
COIN_COLLECTOR_N -- requirements
Module: coin_collector_n

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_COINS, 4, number of coin channels (1..16).
- COORD_W, 10, coordinate width.
- SCORE_W, 7, score width.
- HIT_R2, 100, squared hit radius, inclusive.
- RECYCLE_X, 144, X at or below which a coin respawns.
- COMBO_WINDOW, 60, frames for a combo; used only with COIN_COMBO_EN.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clk, in, 1, system clock.
- Reset_n, in, 1, asynchronous active-low reset.
- frame_clk, in, 1, frame strobe; the rising edge is sampled on Clk.
- Ball_X_Pos, in, COORD_W, ball centre X.
- Ball_Y_Pos, in, COORD_W, ball centre Y.
- coin_X_Pos, in, NUM_COINS*COORD_W, packed coin X; coin i occupies bits [i*COORD_W +: COORD_W].
- coin_Y_Pos, in, NUM_COINS*COORD_W, packed coin Y, same packing as coin_X_Pos.
- game_state, in, 2, 0 = start, 1 = play, 2 = over, 3 = hold.
- score, out, SCORE_W, collected score.
- coin_collected, out, NUM_COINS, per-coin hide flag.
- collect_pulse, out, 1, one-Clk strobe when an evaluation adds score.
- score_sat, out, 1, score is at its maximum value.
- combo_active, out, 1, a combo window is open.

Function
REQ-003 The block SHALL detect a frame tick as frame_clk registered twice on Clk and seen 0 then 1; all evaluations SHALL occur only on that tick.
REQ-004 On a tick in state 1, each coin i SHALL be tested for a hit: dx = coin X minus ball X, dy = coin Y minus ball Y, both signed COORD_W+1 bits; a hit is dx*dx + dy*dy <= HIT_R2, computed without overflow at width 2*COORD_W+3.
REQ-005 A coin SHALL count as a new hit only if coin_collected[i] = 0 and its X > RECYCLE_X.
REQ-006 A coin whose X <= RECYCLE_X SHALL have coin_collected[i] cleared on that tick; recycle SHALL take priority over a hit, and no score is added.
REQ-007 All simultaneous new hits in one tick SHALL each add their value; k hits add k times the value, with no lost increments.
REQ-008 Score SHALL saturate at 2^SCORE_W - 1 and never wrap; score_sat = 1 while score is at that maximum.
REQ-009 collect_pulse SHALL be 1 for exactly the Clk cycle after a tick that added at least one hit, including when the score is already saturated.
REQ-010 State 0 SHALL clear score, every coin_collected bit and the combo state on every Clk cycle, regardless of frame_clk.
REQ-011 States 2 and 3 SHALL hold all state; ticks are ignored.
REQ-012 All outputs SHALL be registered; the update latency SHALL be 1 Clk cycle after tick detection.
REQ-013 A game_state change between ticks SHALL take effect at the next tick; the value sampled at the tick governs that tick.

Reset
REQ-014 Asserting Reset_n = 0 SHALL asynchronously force score = 0, coin_collected = 0, collect_pulse = 0, score_sat = 0, combo_active = 0, the frame-edge synchroniser = 0 and the combo counter = 0.
REQ-015 Reset asserted mid-frame SHALL discard any pending tick; the first tick after release SHALL require a fresh frame_clk 0-to-1 edge.

Configuration
REQ-016 Macro COIN_COMBO_EN defined: the block SHALL keep a frame counter that reloads to COMBO_WINDOW on any scoring tick and decrements (floor 0) on other play ticks.
- combo_active = 1 while the counter is nonzero.
- Hits on a tick where combo_active was already 1 SHALL add 2 each; otherwise 1 each.
REQ-017 Macro COIN_COMBO_EN undefined: no counter SHALL be built, combo_active SHALL be tied to 0, and every hit SHALL add 1.

Verification
REQ-018 Defaults, ball (200,100), coin0 (206,108), game_state 1, one tick -> score 1, coin_collected[0] = 1, one collect_pulse; second tick -> score stays 1.
REQ-019 Coins 0, 1 and 2 all within radius on the same tick -> score +3, coin_collected = 4'b0111.
REQ-020 coin1 at X = 144 overlapping the ball -> no score, coin_collected[1] = 0; coin1 at X = 145 overlapping -> score +1.
REQ-021 Score preloaded to 126 via hits, then 2 simultaneous hits -> score 127, score_sat = 1, collect_pulse = 1; further hits -> score stays 127.
REQ-022 game_state 2 with an overlapping coin -> no change; game_state 0 -> score and flags clear within 1 Clk; Reset_n pulsed low mid-frame -> all outputs 0 immediately.
REQ-023 With COIN_COMBO_EN, hit, then another hit 10 ticks later -> +1 then +2; a hit 61 ticks after the last score -> +1, with combo_active falling after 60 ticks.
